cpu_bus_bridge: RTL and testbench
=================================

# cpu_bus_bridge

Bus master bridge between the CPU data-memory port and the peripheral slave bus. Accepts one CPU load/store at a time over a valid/ready handshake, decodes the address into a one-hot slave chip-enable, drives the shared `ce/we/addr/din` slave strobes for a fixed access window, samples the selected slave's `dout`, and returns a response. The GPIO block is slave 0 on its output side.

## Interface
- `NUM_SLAVES`, 4: number of slave ports, 1..16
- `WAIT_STATES`, 0: extra ACCESS cycles before the strobe cycle, 0..7
- `BASE_HI`, 16'h4000: required value of `req_addr[31:16]` for a mapped access

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in 1: CPU request present
- `req_ready` out 1: bridge accepts request this cycle
- `req_we` in 1: 1 = store, 0 = load
- `req_addr` in 32: byte address
- `req_wdata` in 32: store data
- `rsp_valid` out 1: response present
- `rsp_ready` in 1: CPU consumes response
- `rsp_rdata` out 32: load data; 0 for stores and errors
- `rsp_err` out 1: unmapped address
- `ce` out NUM_SLAVES: one-hot slave chip-enable
- `we` out 1: write strobe, shared
- `addr` out 3: word offset within slave, shared
- `din` out 32: write data to slaves, shared
- `slv_dout` in 32*NUM_SLAVES: read data, slave i at bits [32*i+31:32*i]; combinational from slave

## Operation
- Decode: mapped iff `req_addr[31:16]==BASE_HI` and `req_addr[15:12] < NUM_SLAVES`; slave index = `req_addr[15:12]`; `addr = req_addr[4:2]`; bits [11:5] and [1:0] ignored (aliased).
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `req_ready=1`. On `req_valid`: latch we, addr, wdata, index, mapped flag. Mapped -> ACCESS, wait counter = 0. Unmapped -> RESP with `rsp_err=1`, `rsp_rdata=0`; no slave strobe.
- ACCESS: lasts `WAIT_STATES+1` cycles. Counter increments each cycle; `addr`, `din`, slave select held stable throughout. `ce[idx]` and `we` (for stores) asserted only on final cycle (counter==WAIT_STATES). Loads: `slv_dout[idx]` registered into `rsp_rdata` on that same edge. Stores: `rsp_rdata=0`. -> RESP.
- RESP: `rsp_valid=1`, `rsp_rdata`/`rsp_err` held stable. On `rsp_ready` -> IDLE. `req_ready=0`.
- Outside the strobe cycle: `ce=0`, `we=0`. `addr`/`din` are don't-care there but must not glitch during ACCESS.
- Only one transaction outstanding; no request accepted in ACCESS or RESP.

## Timing
- Reset values: `req_ready=0` while `rst` high, 1 in first cycle after; `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `ce=0`, `we=0`, `addr=0`, `din=0`; state IDLE, counter 0.
- Accept edge T. ACCESS cycles T+1..T+1+W. Strobe cycle T+1+W. `rsp_valid` high from T+2+W.
- Unmapped: `rsp_valid` high from T+1.
- `rsp_ready` high in first RESP cycle: `req_ready` high next cycle. Back-to-back throughput is 3+W cycles per mapped access.
- `rsp_ready` asserted outside RESP is ignored.
- `req_valid` held through ACCESS/RESP is not re-accepted until IDLE.
- Reset mid-ACCESS or mid-RESP: next cycle is IDLE with reset values. Transaction dropped, no response, strobe deasserted immediately.

## Structure
- Shared package `bus_pkg`: `BASE_HI` default, slave index constants (`SLV_GPIO=0`, others reserved), FSM state encoding, `SLV_ADDR_W=3`.
- One combinational sub-module `bus_addr_decode`: `req_addr` -> (mapped, index, word offset). Reused by future bus masters.

## Test plan
- Store 0x1 to 0x4000_0000, W=0: `ce=4'b0001`, `we=1`, `addr=0`, `din=1` for exactly one cycle at T+1; `rsp_valid` at T+2, `rsp_err=0`, `rsp_rdata=0`.
- Load 0x4000_2008 with slave 2 `dout=32'hCAFE_0001`, W=2: `ce=4'b0100` only at T+3, `addr=2`, `we=0`; `rsp_rdata=32'hCAFE_0001` at T+4.
- Load 0x5000_0000 and 0x4000_7000 (NUM_SLAVES=4): no `ce` ever asserted; `rsp_valid` at T+1 with `rsp_err=1`, `rsp_rdata=0`.
- Response backpressure: hold `rsp_ready=0` for 5 cycles with `req_valid=1` continuously: `rsp_*` stable, `req_ready=0` throughout; second request accepted the cycle after `rsp_ready=1`.
- Assert `rst` during ACCESS (W=3, cycle T+2): no `ce` pulse afterwards, `rsp_valid` never asserted, `req_ready=1` the cycle after `rst` drops.
- Back-to-back stores with `rsp_ready` tied 1, W=0: accepts spaced exactly 3 cycles apart.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for peripheral bus masters: address map constants,
// slave numbering and the bridge FSM state encoding.
package bus_pkg;

  localparam logic [15:0] BASE_HI_DEF = 16'h4000;

  // Slave 0 is the GPIO block; the remaining indices are reserved.
  localparam int unsigned SLV_GPIO = 0;

  localparam int unsigned SLV_ADDR_W = 3;
  localparam int unsigned SLV_IDX_W  = 4;
  localparam int unsigned WAIT_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: byte address -> mapped flag, slave index
// and word offset within the slave. Shared by all peripheral bus masters.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [15:0] BASE_HI    = BASE_HI_DEF
) (
  input  logic [31:0]           req_addr,
  output logic                  mapped,
  output logic [SLV_IDX_W-1:0]  idx,
  output logic [SLV_ADDR_W-1:0] word_off
);

  // Bits [11:5] and [1:0] alias: slaves only decode a word offset.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[11:5], req_addr[1:0]};

  assign idx      = req_addr[15:12];
  assign word_off = req_addr[4:2];
  assign mapped   = (req_addr[31:16] == BASE_HI) && (32'(idx) < NUM_SLAVES);

endmodule

// File: rtl/cpu_bus_bridge.sv
// CPU data port to peripheral slave bus bridge: one transaction at a time,
// fixed-length access window with a single-cycle ce/we strobe at its end.
module cpu_bus_bridge
  import bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [15:0] BASE_HI     = BASE_HI_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  // Handshakes: a request transfers on a rising edge where req_valid and
  // req_ready are both high; a response transfers where rsp_valid and
  // rsp_ready are both high. rsp_ready outside RESP has no effect.
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic [NUM_SLAVES-1:0]   ce,
  output logic                    we,
  output logic [SLV_ADDR_W-1:0]   addr,
  output logic [31:0]             din,
  input  logic [32*NUM_SLAVES-1:0] slv_dout,
  output bus_state_e              dbg_state_o
);

  localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(WAIT_STATES);

  bus_state_e              state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [SLV_ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]             din_q, din_d;
  logic [SLV_IDX_W-1:0]    idx_q, idx_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    dec_mapped;
  logic [SLV_IDX_W-1:0]    dec_idx;
  logic [SLV_ADDR_W-1:0]   dec_off;
  logic                    access_last;
  logic                    strobe;
  logic [31:0]             sel_dout;

  bus_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_HI    (BASE_HI)
  ) u_decode (
    .req_addr (req_addr),
    .mapped   (dec_mapped),
    .idx      (dec_idx),
    .word_off (dec_off)
  );

  assign access_last = (state_q == ST_ACCESS) && (cnt_q == LAST_CNT);
  // Gated by rst so a reset mid-access drops the strobe in the same cycle.
  assign strobe      = access_last && !rst;

  always_comb begin
    sel_dout = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (idx_q == SLV_IDX_W'(i)) sel_dout = slv_dout[32*i +: 32];
    end
  end

  always_comb begin
    ce = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      ce[i] = strobe && (idx_q == SLV_IDX_W'(i));
    end
  end

  assign we          = strobe && we_q;
  assign addr        = addr_q;
  assign din         = din_q;
  assign req_ready   = (state_q == ST_IDLE) && !rst;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = dec_off;
          din_d   = req_wdata;
          idx_d   = dec_idx;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = !dec_mapped;
          // Unmapped requests skip the bus entirely and answer with an error.
          state_d = dec_mapped ? ST_ACCESS : ST_RESP;
        end
      end
      ST_ACCESS: begin
        if (access_last) begin
          if (!we_q) rdata_d = sel_dout;
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Self-checking bench for cpu_bus_bridge: emulated register-file slaves,
// transaction-level reference memory, directed and randomized traffic.
module tb_cpu_bus_bridge;
  import bus_pkg::*;

  localparam int          NS = 4;
  localparam int          W  = 2;
  localparam logic [15:0] BH = 16'h4000;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [NS-1:0]     ce;
  logic              we;
  logic [2:0]        addr;
  logic [31:0]       din;
  logic [32*NS-1:0]  slv_dout;
  bus_state_e        dbg_state;

  int n_chk = 0;
  int n_bad = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  bit prev_done = 0;

  logic [31:0] slv_mem [NS][8];
  logic [31:0] ref_mem [NS][8];

  cpu_bus_bridge #(
    .NUM_SLAVES  (NS),
    .WAIT_STATES (W),
    .BASE_HI     (BH)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .ce          (ce),
    .we          (we),
    .addr        (addr),
    .din         (din),
    .slv_dout    (slv_dout),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_val(input int s, input int w);
    if (s == 2 && w == 2) return 32'hCAFE_0001;
    return 32'((s + 1) * 32'h1000_0000 + w * 32'h0101);
  endfunction

  // Slave emulation: small register files, combinational read.
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (rst) slv_mem[i][j] <= init_val(i, j);
        else if (ce[i] && we && addr == 3'(j)) slv_mem[i][j] <= din;
      end
    end
  end

  always_comb begin
    slv_dout = '0;
    for (int i = 0; i < NS; i++) slv_dout[32*i +: 32] = slv_mem[i][addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic ref_init();
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < 8; j++) ref_mem[i][j] = init_val(i, j);
  endtask

  // Driver tasks
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check_val("rst_req_ready", 32'(req_ready), 32'd0);
    end
    rst = 1'b0;
    ref_init();
    @(negedge clk);
    check_val("rst_req_ready_after", 32'(req_ready), 32'd1);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_val("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_val("rst_ce", 32'(ce), 32'd0);
    check_val("rst_we", 32'(we), 32'd0);
    check_val("rst_addr", 32'(addr), 32'd0);
    check_val("rst_din", din, 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    prev_done = 0;
  endtask

  task automatic run_txn(input logic t_we, input logic [31:0] t_addr,
                         input logic [31:0] t_wdata, input int hold, input bit keep);
    bit          mapped;
    int          idx;
    int          off;
    int          strobe_k;
    int          rsp_k;
    logic        acc;
    logic [31:0] exp_rd;
    logic [NS-1:0] oh;
    idx      = int'(t_addr[15:12]);
    off      = int'(t_addr[4:2]);
    mapped   = (t_addr[31:16] == BH) && (idx < NS);
    strobe_k = W + 1;
    rsp_k    = mapped ? W + 2 : 1;
    exp_rd   = '0;
    oh       = '0;
    if (mapped) begin
      oh[idx] = 1'b1;
      if (!t_we) exp_rd = ref_mem[idx][off];
    end

    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      if (t == 0 && prev_done) check_val("ready_after_rsp", 32'(req_ready), 32'd1);
      acc       = req_ready;
      acc_cyc   = cyc;
      req_valid = 1'b1;
      req_we    = t_we;
      req_addr  = t_addr;
      req_wdata = t_wdata;
      rsp_ready = 1'($urandom_range(0, 1));
    end
    prev_done = 0;
    check_val("accept", 32'(acc), 32'd1);

    for (int k = 1; k < rsp_k; k++) begin
      @(negedge clk);
      if (k == strobe_k) begin
        check_val("strobe_ce", 32'(ce), 32'(oh));
        check_val("strobe_we", 32'(we), 32'(t_we));
        if (t_we) check_val("strobe_din", din, t_wdata);
      end else begin
        check_val("idle_ce", 32'(ce), 32'd0);
        check_val("idle_we", 32'(we), 32'd0);
      end
      check_val("access_addr", 32'(addr), 32'(off));
      check_val("access_rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("access_req_ready", 32'(req_ready), 32'd0);
      req_valid = keep;
      rsp_ready = 1'($urandom_range(0, 1));
    end

    @(negedge clk);
    check_val("rsp_valid", 32'(rsp_valid), 32'd1);
    check_val("rsp_err", 32'(rsp_err), 32'(!mapped));
    check_val("rsp_rdata", rsp_rdata, exp_rd);
    check_val("rsp_req_ready", 32'(req_ready), 32'd0);
    check_val("rsp_ce", 32'(ce), 32'd0);
    req_valid = keep;
    rsp_ready = (hold == 0);
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      check_val("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check_val("hold_rsp_rdata", rsp_rdata, exp_rd);
      check_val("hold_rsp_err", 32'(rsp_err), 32'(!mapped));
      check_val("hold_req_ready", 32'(req_ready), 32'd0);
      check_val("hold_ce", 32'(ce), 32'd0);
      rsp_ready = (h == hold);
    end

    if (mapped && t_we) ref_mem[idx][off] = t_wdata;
    prev_done = 1;
  endtask

  task automatic rst_mid_access();
    @(negedge clk);
    check_val("rm_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1;
    req_addr = 32'h4000_100C; req_wdata = 32'hDEAD_BEEF; rsp_ready = 1'b0;
    @(negedge clk);
    check_val("rm_ce_t1", 32'(ce), 32'd0);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_val("rm_ce_rst", 32'(ce), 32'd0);
    check_val("rm_we_rst", 32'(we), 32'd0);
    check_val("rm_ready_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    ref_init();
    @(negedge clk);
    check_val("rm_ready_after", 32'(req_ready), 32'd1);
    check_val("rm_addr", 32'(addr), 32'd0);
    check_val("rm_din", din, 32'd0);
    check_val("rm_rdata", rsp_rdata, 32'd0);
    for (int k = 0; k < W + 3; k++) begin
      check_val("rm_no_ce", 32'(ce), 32'd0);
      check_val("rm_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    prev_done = 0;
  endtask

  initial begin
    logic [3:0]  r_sl;
    logic [15:0] r_hi;
    logic [11:0] r_lo;
    logic [31:0] r_addr;
    int unsigned prev_acc;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    do_reset(3);

    run_txn(1'b1, 32'h4000_0000, 32'h0000_0001, 0, 1'b0);
    run_txn(1'b0, 32'h4000_2008, 32'h0, 0, 1'b0);
    run_txn(1'b0, 32'h4000_0000, 32'h0, 0, 1'b0);
    run_txn(1'b0, 32'h5000_0000, 32'h0, 0, 1'b0);
    run_txn(1'b0, 32'h4000_7000, 32'h0, 1, 1'b0);

    // Response backpressure with req_valid held continuously.
    run_txn(1'b0, 32'h4000_1004, 32'h0, 5, 1'b1);
    run_txn(1'b1, 32'h4000_3010, $urandom, 0, 1'b1);

    // Aliased address bits select the same slave word.
    run_txn(1'b1, 32'h4000_1FE7, 32'h1234_5678, 0, 1'b0);
    run_txn(1'b0, 32'h4000_1004, 32'h0, 0, 1'b0);

    // Back-to-back stores, response consumed immediately.
    prev_acc = 0;
    for (int i = 0; i < 5; i++) begin
      run_txn(1'b1, {BH, 4'(i % NS), 7'($urandom), 3'($urandom), 2'b00}, $urandom, 0, 1'b1);
      if (i > 0) check_val("b2b_gap", acc_cyc - prev_acc, 32'(3 + W));
      prev_acc = acc_cyc;
    end

    rst_mid_access();

    for (int i = 0; i < 60; i++) begin
      r_sl = 4'($urandom_range(0, NS - 1));
      r_lo = 12'($urandom);
      r_hi = BH;
      case ($urandom_range(0, 9))
        7:       r_sl = 4'($urandom_range(NS, 15));
        8, 9:    begin
                   r_hi = 16'($urandom_range(0, 16'hFFFF));
                   if (r_hi == BH) r_hi = 16'h5000;
                 end
        default: ;
      endcase
      r_addr = {r_hi, r_sl, r_lo};
      run_txn(1'($urandom_range(0, 1)), r_addr, $urandom,
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check_val("final_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
